// File: rtl/mcp3_pkg.sv
// mcp3_pkg: shared requester count, index width, arbiter state encoding and one-hot-to-index helper.
package mcp3_pkg;
    localparam int N_REQ = 6;
    localparam int IDX_W = 3;
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, FAULT = 2'd2} state_t;
    // OR of set-bit positions; exact for one-hot input, 0 for an all-zero input.
    function automatic logic [IDX_W-1:0] oh2idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (oh[i]) idx = idx | IDX_W'(i);
        return idx;
    endfunction
endpackage

// File: rtl/mcp3_arb06_if.sv
// mcp3_arb06_if: arbiter bus.
//   req[5:0] level requests, enable permits new grants, done releases the grant,
//   err_clear clears sticky errors; gnt[5:0] one-hot grant, gnt_valid, gnt_id[2:0],
//   timeout_err and one_hot_err sticky flags. slave = arbiter side, master = client side.
interface mcp3_arb06_if;
    import mcp3_pkg::*;
    logic [N_REQ-1:0] req;
    logic             enable;
    logic             done;
    logic             err_clear;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_id;
    logic             timeout_err;
    logic             one_hot_err;
    modport slave (input req, enable, done, err_clear,
                   output gnt, gnt_valid, gnt_id, timeout_err, one_hot_err);
    modport master (output req, enable, done, err_clear,
                    input gnt, gnt_valid, gnt_id, timeout_err, one_hot_err);
endinterface

// File: rtl/mcp3_rrp06.sv
// mcp3_rrp06: combinational round-robin pick.
//   req[5:0] requests, ptr[2:0] search start; win[5:0] one-hot first set req at or above ptr, wrapping.
module mcp3_rrp06
    import mcp3_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win
);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
    logic [N_REQ-1:0] upper;
    logic [N_REQ-1:0] pick;
    // Prefer requests at or above ptr; otherwise wrap to the full vector, then isolate the lowest set bit.
    assign upper = req & ~((ONE << ptr) - ONE);
    assign pick  = (|upper) ? upper : req;
    assign win   = pick & (~pick + ONE);
endmodule

// File: rtl/mcp3_arb06.sv
// mcp3_arb06: 6-way round-robin arbiter with hold timeout and grant-encoding fault detection.
//   clock, reset_n (async active-low), bus: slave side of mcp3_arb06_if.
//   MAX_HOLD: max cycles a grant is held without done (0 disables the timeout).
module mcp3_arb06
    import mcp3_pkg::*;
#(
    parameter logic [7:0] MAX_HOLD = 8'd64
) (
    input  logic         clock,
    input  logic         reset_n,
    mcp3_arb06_if.slave  bus
);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
    state_t           state, state_n;
    logic [N_REQ-1:0] gnt_q, gnt_n, win;
    logic             gv_q, gv_n, terr_q, terr_n, oh_q, oh_n, bad, tmo;
    logic [IDX_W-1:0] ptr_q, ptr_n, id, nxt, ptr_sel;
    logic [7:0]       cnt_q, cnt_n;
    assign id  = oh2idx(gnt_q);
    assign nxt = (id == IDX_W'(N_REQ - 1)) ? '0 : id + IDX_W'(1);
    assign bad = gv_q ? (gnt_q == '0 || (gnt_q & (gnt_q - ONE)) != '0) : (gnt_q != '0);
    assign tmo = (MAX_HOLD != 8'd0) && (cnt_q == MAX_HOLD - 8'd1);
    // A release searches from the slot after the current grantee so back-to-back grants rotate.
    assign ptr_sel = (state == GRANT) ? nxt : ptr_q;
    mcp3_rrp06 u_rrp (.req(bus.req), .ptr(ptr_sel), .win(win));
    assign bus.gnt         = gnt_q;
    assign bus.gnt_valid   = gv_q;
    assign bus.gnt_id      = gv_q ? id : '0;
    assign bus.timeout_err = terr_q;
    assign bus.one_hot_err = oh_q;
    always_comb begin
        state_n = state;
        gnt_n   = gnt_q;
        gv_n    = gv_q;
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        terr_n  = terr_q & ~bus.err_clear;
        oh_n    = oh_q & ~bus.err_clear;
        if (bad) begin
            oh_n    = 1'b1;
            gnt_n   = '0;
            gv_n    = 1'b0;
            state_n = FAULT;
        end else begin
            unique case (state)
                IDLE: if (bus.enable && bus.req != '0) begin
                    gnt_n   = win;
                    gv_n    = 1'b1;
                    cnt_n   = '0;
                    state_n = GRANT;
                end
                GRANT: if (bus.done) begin
                    ptr_n = nxt;
                    cnt_n = '0;
                    if (bus.enable && bus.req != '0) begin
                        gnt_n = win;
                    end else begin
                        gnt_n   = '0;
                        gv_n    = 1'b0;
                        state_n = IDLE;
                    end
                end else if (tmo) begin
                    ptr_n   = nxt;
                    gnt_n   = '0;
                    gv_n    = 1'b0;
                    terr_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
                FAULT: if (bus.err_clear) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            gnt_q  <= '0;
            gv_q   <= 1'b0;
            ptr_q  <= '0;
            cnt_q  <= '0;
            terr_q <= 1'b0;
            oh_q   <= 1'b0;
        end else begin
            state  <= state_n;
            gnt_q  <= gnt_n;
            gv_q   <= gv_n;
            ptr_q  <= ptr_n;
            cnt_q  <= cnt_n;
            terr_q <= terr_n;
            oh_q   <= oh_n;
        end
    end
endmodule
